// File: rtl/mc_if.sv
`timescale 1ns/1ps
// Control bundle between the multicycle datapath and its controller:
// instruction fields and the ALU zero flag in, control strobes out.
interface mc_if;
  logic [5:0] opc;
  logic [5:0] func;
  logic       zero;
  logic       PCLoad;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       JalSig1;
  logic       MemToReg;
  logic       JalSig2;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOperation;
  logic [1:0] PCSrc;
  logic       instr_done;

  modport master (
    input  opc, func, zero,
    output PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1, MemToReg,
           JalSig2, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc, instr_done
  );

  modport slave (
    output opc, func, zero,
    input  PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1, MemToReg,
           JalSig2, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc, instr_done
  );
endinterface

// File: rtl/mc_controller.sv
`timescale 1ns/1ps
// Multicycle MIPS control FSM. Outputs are registered together with the state;
// only the branch PCLoad looks at zero combinationally.
//
// state   | meaning
// IDLE    | after reset, all outputs low
// FETCH   | read instruction, PC <= PC + 4
// DECODE  | branch target into ALUOut, dispatch on opc
// R_EX    | R-type ALU operation
// R_WB    | write ALUOut to rd
// MEM_ADR | load/store address
// LW_MEM  | data memory read
// LW_WB   | write MDR to rt
// SW_MEM  | data memory write
// BEQ/BNE | compare, conditional PC <= ALUOut
// J/JAL   | jump (JAL also links r31)
// JR      | PC <= A
// I_EX    | addi/slti ALU operation
// I_WB    | write ALUOut to rt
module mc_controller (
  input  logic clk,
  input  logic rst,
  mc_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, R_EX, R_WB, MEM_ADR, LW_MEM, LW_WB,
    SW_MEM, BEQ, BNE, J, JAL, JR, I_EX, I_WB
  } state_t;

  typedef struct packed {
    logic       pcLoad;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       jalSig1;
    logic       memToReg;
    logic       jalSig2;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSrc;
    logic       done;
    logic       isBeq;
    logic       isBne;
  } ctrl_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t state;
  ctrl_t  ctrl;
  logic   armed;

  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
    state_t n;
    case (op)
      OP_RTYPE:      n = (fn == FN_JR) ? JR : R_EX;
      OP_LW, OP_SW:  n = MEM_ADR;
      OP_BEQ:        n = BEQ;
      OP_BNE:        n = BNE;
      OP_J:          n = J;
      OP_JAL:        n = JAL;
      OP_ADDI, OP_SLTI: n = I_EX;
      default:       n = FETCH;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] rTypeOp(input logic [5:0] fn);
    logic [2:0] o;
    case (fn)
      6'b100010: o = ALU_SUB;
      6'b100100: o = ALU_AND;
      6'b100101: o = ALU_OR;
      6'b101010: o = ALU_SLT;
      default:   o = ALU_ADD;
    endcase
    return o;
  endfunction

  // Holding IDLE until armed puts the first FETCH on the second edge after release.
  function automatic state_t advance(input state_t s, input logic go,
                                     input logic [5:0] op, input logic [5:0] fn);
    state_t n;
    case (s)
      IDLE:    n = go ? FETCH : IDLE;
      FETCH:   n = DECODE;
      DECODE:  n = dispatch(op, fn);
      R_EX:    n = R_WB;
      MEM_ADR: n = (op == OP_LW) ? LW_MEM : SW_MEM;
      LW_MEM:  n = LW_WB;
      I_EX:    n = I_WB;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t ctrlFor(input state_t s, input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.memRead = 1'b1; c.irWrite = 1'b1; c.aluSrcB = 2'b01;
        c.aluOp = ALU_ADD; c.pcLoad = 1'b1;
      end
      DECODE: begin
        c.aluSrcB = 2'b11; c.aluOp = ALU_ADD;
        c.done = (dispatch(op, fn) == FETCH);
      end
      R_EX:    begin c.aluSrcA = 1'b1; c.aluOp = rTypeOp(fn); end
      R_WB:    begin c.regDst = 1'b1; c.memToReg = 1'b1; c.regWrite = 1'b1; c.done = 1'b1; end
      MEM_ADR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = ALU_ADD; end
      LW_MEM:  begin c.iorD = 1'b1; c.memRead = 1'b1; end
      LW_WB:   begin c.regWrite = 1'b1; c.done = 1'b1; end
      SW_MEM:  begin c.iorD = 1'b1; c.memWrite = 1'b1; c.done = 1'b1; end
      BEQ, BNE: begin
        c.aluSrcA = 1'b1; c.aluOp = ALU_SUB; c.pcSrc = 2'b10; c.done = 1'b1;
        c.isBeq = (s == BEQ); c.isBne = (s == BNE);
      end
      J:       begin c.pcSrc = 2'b01; c.pcLoad = 1'b1; c.done = 1'b1; end
      JAL: begin
        c.pcSrc = 2'b01; c.pcLoad = 1'b1; c.jalSig1 = 1'b1; c.jalSig2 = 1'b1;
        c.regWrite = 1'b1; c.done = 1'b1;
      end
      JR:      begin c.pcSrc = 2'b11; c.pcLoad = 1'b1; c.done = 1'b1; end
      I_EX: begin
        c.aluSrcA = 1'b1; c.aluSrcB = 2'b10;
        c.aluOp = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      I_WB:    begin c.memToReg = 1'b1; c.regWrite = 1'b1; c.done = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0;
      state <= IDLE;
      ctrl  <= '0;
    end else begin
      armed <= 1'b1;
      state <= advance(state, armed, bus.opc, bus.func);
      ctrl  <= ctrlFor(advance(state, armed, bus.opc, bus.func), bus.opc, bus.func);
    end
  end

  assign bus.PCLoad       = ctrl.pcLoad | (ctrl.isBeq & bus.zero) | (ctrl.isBne & ~bus.zero);
  assign bus.IorD         = ctrl.iorD;
  assign bus.MemRead      = ctrl.memRead;
  assign bus.MemWrite     = ctrl.memWrite;
  assign bus.IRWrite      = ctrl.irWrite;
  assign bus.RegDst       = ctrl.regDst;
  assign bus.JalSig1      = ctrl.jalSig1;
  assign bus.MemToReg     = ctrl.memToReg;
  assign bus.JalSig2      = ctrl.jalSig2;
  assign bus.RegWrite     = ctrl.regWrite;
  assign bus.ALUSrcA      = ctrl.aluSrcA;
  assign bus.ALUSrcB      = ctrl.aluSrcB;
  assign bus.ALUOperation = ctrl.aluOp;
  assign bus.PCSrc        = ctrl.pcSrc;
  assign bus.instr_done   = ctrl.done;
endmodule

// File: tb/tb_mc_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for mc_controller: each instruction queues its expected
// per-cycle control words; a monitor compares every non-idle cycle.
module tb_mc_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mc_if bus();

  mc_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // {PCLoad,IorD,MemRead,MemWrite,IRWrite,RegDst,JalSig1,MemToReg,JalSig2,RegWrite,ALUSrcA}_SrcB_Op_PCSrc_done
  typedef logic [18:0] word_t;
  localparam word_t E_IF      = 19'b10101000000_01_010_00_0;
  localparam word_t E_ID      = 19'b00000000000_11_010_00_0;
  localparam word_t E_ID_BAD  = 19'b00000000000_11_010_00_1;
  localparam word_t E_MEMADR  = 19'b00000000001_10_010_00_0;
  localparam word_t E_LWMEM   = 19'b01100000000_00_000_00_0;
  localparam word_t E_LWWB    = 19'b00000000010_00_000_00_1;
  localparam word_t E_SWMEM   = 19'b01010000000_00_000_00_1;
  localparam word_t E_REX_ADD = 19'b00000000001_00_010_00_0;
  localparam word_t E_REX_SUB = 19'b00000000001_00_110_00_0;
  localparam word_t E_REX_AND = 19'b00000000001_00_000_00_0;
  localparam word_t E_REX_OR  = 19'b00000000001_00_001_00_0;
  localparam word_t E_REX_SLT = 19'b00000000001_00_111_00_0;
  localparam word_t E_RWB     = 19'b00000101010_00_000_00_1;
  localparam word_t E_BR_LOAD = 19'b10000000001_00_110_10_1;
  localparam word_t E_BR_NOLD = 19'b00000000001_00_110_10_1;
  localparam word_t E_J       = 19'b10000000000_00_000_01_1;
  localparam word_t E_JAL     = 19'b10000010110_00_000_01_1;
  localparam word_t E_JR      = 19'b10000000000_00_000_11_1;
  localparam word_t E_IEX_ADD = 19'b00000000001_10_010_00_0;
  localparam word_t E_IEX_SLT = 19'b00000000001_10_111_00_0;
  localparam word_t E_IWB     = 19'b00000001010_00_000_00_1;
  localparam word_t Z         = 19'b0;

  word_t expQ[$];
  string tagQ[$];
  int    vectors = 0;
  int    miscompares = 0;
  word_t obs;

  assign obs = {bus.PCLoad, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
                bus.JalSig1, bus.MemToReg, bus.JalSig2, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOperation, bus.PCSrc, bus.instr_done};

  task automatic check(input string name, input word_t act, input word_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: every cycle out of reset with any output active consumes one expectation.
  initial begin
    word_t e;
    string t;
    forever begin
      @(negedge clk);
      if (rst && obs != Z) begin
        if (expQ.size() == 0) begin
          check("unexpected output", obs, Z);
        end else begin
          e = expQ.pop_front();
          t = tagQ.pop_front();
          check(t, obs, e);
        end
        check("memread/memwrite exclusive", {18'b0, bus.MemRead & bus.MemWrite}, Z);
      end
    end
  end

  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int n,
                     input word_t e0, input word_t e1, input word_t e2,
                     input word_t e3, input word_t e4);
    word_t seq[5];
    int    cnt;
    logic  done;
    seq = '{e0, e1, e2, e3, e4};
    @(posedge clk);
    #2;
    bus.opc = op;
    bus.func = fn;
    bus.zero = z;
    for (int i = 0; i < n; i++) begin
      expQ.push_back(seq[i]);
      tagQ.push_back($sformatf("%s step %0d", name, i));
    end
    cnt = 0;
    done = 1'b0;
    while (!done && cnt < 12) begin
      @(negedge clk);
      cnt++;
      done = bus.instr_done;
    end
    check({name, " latency"}, word_t'(cnt), word_t'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.opc = 6'b100011;
    bus.func = 6'b000000;
    bus.zero = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("outputs in reset", obs, Z);
    #3 rst = 1'b1;
    @(posedge clk);
    #2 check("idle after release", obs, Z);

    run("lw",      6'b100011, 6'b000000, 1'b0, 5, E_IF, E_ID, E_MEMADR, E_LWMEM, E_LWWB);
    run("r_sub",   6'b000000, 6'b100010, 1'b0, 4, E_IF, E_ID, E_REX_SUB, E_RWB, Z);
    run("r_add",   6'b000000, 6'b100000, 1'b0, 4, E_IF, E_ID, E_REX_ADD, E_RWB, Z);
    run("r_and",   6'b000000, 6'b100100, 1'b0, 4, E_IF, E_ID, E_REX_AND, E_RWB, Z);
    run("r_or",    6'b000000, 6'b100101, 1'b0, 4, E_IF, E_ID, E_REX_OR, E_RWB, Z);
    run("r_slt",   6'b000000, 6'b101010, 1'b0, 4, E_IF, E_ID, E_REX_SLT, E_RWB, Z);
    run("r_other", 6'b000000, 6'b000111, 1'b0, 4, E_IF, E_ID, E_REX_ADD, E_RWB, Z);
    run("beq_z1",  6'b000100, 6'b000000, 1'b1, 3, E_IF, E_ID, E_BR_LOAD, Z, Z);
    run("beq_z0",  6'b000100, 6'b000000, 1'b0, 3, E_IF, E_ID, E_BR_NOLD, Z, Z);
    run("bne_z1",  6'b000101, 6'b000000, 1'b1, 3, E_IF, E_ID, E_BR_NOLD, Z, Z);
    run("bne_z0",  6'b000101, 6'b000000, 1'b0, 3, E_IF, E_ID, E_BR_LOAD, Z, Z);
    run("jal",     6'b000011, 6'b000000, 1'b0, 3, E_IF, E_ID, E_JAL, Z, Z);
    run("j",       6'b000010, 6'b000000, 1'b0, 3, E_IF, E_ID, E_J, Z, Z);
    run("jr",      6'b000000, 6'b001000, 1'b0, 3, E_IF, E_ID, E_JR, Z, Z);
    run("addi",    6'b001000, 6'b000000, 1'b0, 4, E_IF, E_ID, E_IEX_ADD, E_IWB, Z);
    run("slti",    6'b001010, 6'b000000, 1'b0, 4, E_IF, E_ID, E_IEX_SLT, E_IWB, Z);
    run("bad_3f",  6'b111111, 6'b000000, 1'b0, 2, E_IF, E_ID_BAD, Z, Z, Z);
    run("bad_01",  6'b000001, 6'b001000, 1'b0, 2, E_IF, E_ID_BAD, Z, Z, Z);
    run("sw",      6'b101011, 6'b000000, 1'b0, 4, E_IF, E_ID, E_MEMADR, E_SWMEM, Z);

    // Store aborted by reset while the write strobe is up.
    @(posedge clk);
    #2;
    bus.opc = 6'b101011;
    bus.func = 6'b000000;
    expQ.push_back(E_IF);     tagQ.push_back("sw_abort step 0");
    expQ.push_back(E_ID);     tagQ.push_back("sw_abort step 1");
    expQ.push_back(E_MEMADR); tagQ.push_back("sw_abort step 2");
    expQ.push_back(E_SWMEM);  tagQ.push_back("sw_abort step 3");
    repeat (4) @(negedge clk);
    #1 check("sw_mem before reset", obs, E_SWMEM);
    rst = 1'b0;
    #1;
    check("memwrite after async reset", {18'b0, bus.MemWrite}, Z);
    check("outputs after async reset", obs, Z);
    @(negedge clk);
    check("held in reset", obs, Z);
    check("scoreboard drained", word_t'(expQ.size()), Z);
    #3 rst = 1'b1;
    @(posedge clk);
    #2 check("idle after second release", obs, Z);
    run("j_after_reset", 6'b000010, 6'b000000, 1'b0, 3, E_IF, E_ID, E_J, Z, Z);

    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("final scoreboard drained", word_t'(expQ.size()), Z);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The module SHALL have the port `clk`: input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-002 The module SHALL have the port `rst`: input, 1 bit, asynchronous active-low reset; `rst`=0 forces state IDLE immediately, independent of `clk`.
REQ-003 The module SHALL have the inputs `opc` (6 bits, instruction[31:26]), `func` (6 bits, instruction[5:0]) and `zero` (1 bit, ALU result==0).
REQ-004 The module SHALL have the 1-bit outputs `PCLoad`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `RegDst`, `JalSig1`, `MemToReg`, `JalSig2`, `RegWrite` and `ALUSrcA`.
REQ-005 The module SHALL have the outputs `ALUSrcB` (2 bits), `ALUOperation` (3 bits) and `PCSrc` (2 bits).
REQ-006 The module SHALL have the output `instr_done`: 1 bit, one-cycle pulse in the final state of every instruction, including unsupported opcodes.

Function
REQ-007 Encodings SHALL be fixed as follows:
- `ALUSrcA`: 0=PC, 1=A.
- `ALUSrcB`: 00=B, 01=4, 10=sign-extended immediate, 11=sign-extended immediate<<2.
- `PCSrc`: 00=ALU result, 01=jump address, 10=ALUOut, 11=A.
- `MemToReg`: 0=MDR, 1=ALUOut.
- `ALUOperation`: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-008 The controller SHALL be a registered-state FSM; every output not listed for a state SHALL be 0 in that state.
REQ-009 IDLE SHALL drive all outputs to 0 and go to IF on the next edge.
REQ-010 IF SHALL assert `MemRead`=1, `IorD`=0, `IRWrite`=1, `ALUSrcA`=0, `ALUSrcB`=01, ADD, `PCSrc`=00 and `PCLoad`=1, then go to ID.
REQ-011 ID SHALL drive `ALUSrcA`=0, `ALUSrcB`=11 and ADD to form the branch target, then dispatch on `opc`:
- 000000 with `func`=001000 -> JR; 000000 with any other `func` -> R_EX.
- 100011 or 101011 -> MEM_ADR.
- 000100 -> BEQ; 000101 -> BNE.
- 000010 -> J; 000011 -> JAL.
- 001000 or 001010 -> I_EX.
- Any other value -> IF.
REQ-012 An unsupported opcode SHALL pulse `instr_done` in ID and have no architectural effect.
REQ-013 R_EX SHALL drive `ALUSrcA`=1 and `ALUSrcB`=00, with `func` mapped to ALUOperation: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, others ADD; it SHALL then go to R_WB.
REQ-014 R_WB SHALL assert `RegDst`=1, `MemToReg`=1 and `RegWrite`=1 and pulse `instr_done`, then go to IF.
REQ-015 MEM_ADR SHALL drive `ALUSrcA`=1, `ALUSrcB`=10 and ADD, then go to LW_MEM if `opc`=100011, else SW_MEM.
REQ-016 LW_MEM SHALL assert `IorD`=1 and `MemRead`=1, then go to LW_WB.
REQ-017 LW_WB SHALL assert `RegDst`=0, `MemToReg`=0 and `RegWrite`=1 and pulse `instr_done`, then go to IF.
REQ-018 SW_MEM SHALL assert `IorD`=1 and `MemWrite`=1 and pulse `instr_done`, then go to IF.
REQ-019 BEQ/BNE SHALL drive `ALUSrcA`=1, `ALUSrcB`=00, SUB and `PCSrc`=10; `PCLoad` SHALL equal `zero` (BEQ) or ~`zero` (BNE), combinationally, which is the only Mealy output; each SHALL pulse `instr_done`, then go to IF.
REQ-020 J SHALL assert `PCSrc`=01 and `PCLoad`=1 and pulse `instr_done`, then go to IF.
REQ-021 JAL SHALL assert `PCSrc`=01, `PCLoad`=1, `JalSig1`=1, `JalSig2`=1 and `RegWrite`=1 in one state, writing the incremented PC to r31 while loading the target, and pulse `instr_done`, then go to IF.
REQ-022 JR SHALL assert `PCSrc`=11 and `PCLoad`=1 and pulse `instr_done`, then go to IF.
REQ-023 I_EX SHALL drive `ALUSrcA`=1, `ALUSrcB`=10, and ADD (opc 001000) or SLT (opc 001010), then go to I_WB.
REQ-024 I_WB SHALL assert `RegDst`=0, `MemToReg`=1 and `RegWrite`=1 and pulse `instr_done`, then go to IF.
REQ-025 Latency from the IF edge SHALL be: J/JAL/JR/BEQ/BNE/SW 3 cycles; R-type/addi/slti 4 cycles; LW 5 cycles.
REQ-026 `MemRead` and `MemWrite` SHALL never both be 1 in any state.
REQ-027 `PCLoad` SHALL be asserted in at most one state per instruction besides IF.

Reset
REQ-028 While `rst`=0, state SHALL be IDLE and every output, including `instr_done`, SHALL be 0.
REQ-029 Reset asserted mid-instruction SHALL abort it with no further write strobes.
REQ-030 After `rst` rises, the first IF SHALL occur on the second rising edge.
REQ-031 No state encoding SHALL be unreachable-trapping; any illegal state register value SHALL go to IF on the next edge.

Verification
REQ-032 The bench SHALL cover: reset release, then `opc`=100011 -> states IF,ID,MEM_ADR,LW_MEM,LW_WB; `RegWrite`=1 only in LW_WB; `instr_done` on cycle 5.
REQ-033 The bench SHALL cover: `opc`=000000 with `func`=100010 -> `ALUOperation`=110 in R_EX; R_WB has `RegDst`=1, `MemToReg`=1, `RegWrite`=1.
REQ-034 The bench SHALL cover: BEQ with `zero`=1 -> `PCLoad`=1 and `PCSrc`=10; BNE with `zero`=1 -> `PCLoad`=0.
REQ-035 The bench SHALL cover: `opc`=000011 -> one cycle with `PCLoad`, `RegWrite`, `JalSig1`, `JalSig2`=1 and `PCSrc`=01.
REQ-036 The bench SHALL cover: `opc`=111111 -> return to IF after ID with no `RegWrite`, `MemWrite` or `PCLoad` outside IF.
REQ-037 The bench SHALL cover: `rst`=0 asserted in SW_MEM between clock edges -> `MemWrite` drops to 0 immediately.
